puf_race_ctrl: RTL and testbench
================================

// Module: puf_race_ctrl
// PURPOSE
//  Sequencer downstream of the two edge counters in the ring-oscillator PUF.
//  For each response bit: selects an RO pair, clears both counters, enables
//  the ROs and waits for the first counter finished pulse. It records the
//  winner as one response bit, then assembles RESP_BITS bits into a response word.
//  Sits between the RO-pair mux / counter pair and the response readout logic.
// PARAMETERS
//  RESP_BITS   8       number of races (response bits) per start
//  SEL_W       3       width of pair_sel; must satisfy 2**SEL_W >= RESP_BITS
//  CLR_CYCLES  4       cycles counter_rst is held high before each race (>=1)
//  TIMEOUT     65535   max clk cycles in RACE before forcing a bit (>=1)
// PORTS
//  clk        in   1          system clock; all logic rising-edge
//  rst        in   1          asynchronous, active-high reset
//  start      in   1          begin a response run; sampled only in IDLE
//  fin_a      in   1          finished pulse from counter on RO A (clk-synchronous)
//  fin_b      in   1          finished pulse from counter on RO B (clk-synchronous)
//  pair_sel   out  SEL_W      index of the RO pair under test (= current bit index)
//  counter_rst out 1          reset to both counters
//  ro_en      out  1          enable to the selected ring oscillators
//  busy       out  1          high from the cycle after start accept until done
//  done       out  1          one-cycle pulse when response is complete
//  response   out  RESP_BITS  assembled response; bit i = result of race i
//  tie_flag   out  1          sticky: some race saw fin_a and fin_b in same cycle
//  tmo_flag   out  1          sticky: some race hit TIMEOUT
// BEHAVIOUR
//  Reset (async): state=IDLE; pair_sel=0, counter_rst=1, ro_en=0, busy=0,
//   done=0, response=0, tie_flag=0, tmo_flag=0; internal cycle counters = 0.
//  FSM states IDLE, CLEAR, RACE, CAPTURE, DONE:
//   IDLE:  counter_rst=1, ro_en=0. start=1 -> CLEAR; idx=0, response=0, flags=0.
//   CLEAR: counter_rst=1, ro_en=0, pair_sel=idx; stay CLR_CYCLES cycles -> RACE.
//   RACE:  counter_rst=0, ro_en=1; wait-counter increments each cycle.
//          fin_a & !fin_b -> bit=1; fin_b & !fin_a -> bit=0;
//          fin_a & fin_b  -> bit=0, tie_flag<=1;
//          wait-counter reaches TIMEOUT with no fin -> bit=0, tmo_flag<=1.
//          Any of these -> CAPTURE next cycle. Fin pulses outside RACE ignored.
//   CAPTURE: ro_en=0, counter_rst=1; response[idx]<=bit (one cycle).
//          idx==RESP_BITS-1 -> DONE, else idx<=idx+1 -> CLEAR.
//   DONE:  done=1 for exactly one cycle, busy=0 from this cycle -> IDLE.
//  busy=1 in CLEAR, RACE, CAPTURE. start ignored while not in IDLE.
//  response/flags hold their value from DONE until the next accepted start.
//  Latency per bit = CLR_CYCLES + race cycles + 1 (CAPTURE); total run
//   = 1 (accept) + RESP_BITS*(CLR_CYCLES+1) + sum(race cycles) + 1 (DONE).
//  Wait-counter width = clog2(TIMEOUT+1); cleared on every CLEAR entry; never wraps.
//  idx is SEL_W bits; never exceeds RESP_BITS-1.
//  rst asserted mid-run: immediate return to reset values; partial response lost.
// TESTING
//  1 RESP_BITS=8; start; per race drive fin_a 10 cycles after ro_en rises,
//    fin_b 12 cycles -> response=8'hFF, done one pulse, tie/tmo flags 0.
//  2 Alternate winners A,B,A,B,... per bit -> response=8'h55 (bit0=1).
//  3 Race 3 with fin_a&fin_b same cycle, others A wins -> response=8'hF7, tie_flag=1.
//  4 TIMEOUT=20; race 0 no fin pulses -> CAPTURE exactly 20 cycles after RACE entry,
//    response[0]=0, tmo_flag=1; remaining races complete normally.
//  5 Check counter_rst high exactly CLR_CYCLES=4 cycles before each ro_en rise;
//    pair_sel steps 0..7; start pulsed while busy is ignored; fin pulses in CLEAR ignored.
//  6 Assert rst during race 5 -> all outputs at reset values same cycle; new
//    start afterwards yields a full clean run with correct response.

Source files
------------

// File: rtl/puf_race_ctrl.sv
// Ring-oscillator PUF race sequencer.
// For each response bit it clears the counter pair, runs one race and records
// which counter finished first. RESP_BITS races are assembled into one word.
module puf_race_ctrl #(
  parameter int RESP_BITS  = 8,
  parameter int SEL_W      = 3,
  parameter int CLR_CYCLES = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 fin_a,
  input  logic                 fin_b,
  output logic [SEL_W-1:0]     pair_sel,
  output logic                 counter_rst,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 tie_flag,
  output logic                 tmo_flag
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CLR_CYCLES + 1);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(RESP_BITS - 1);
  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
  localparam logic [CW-1:0]    CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0]    CLR_ONE  = CW'(1);
  localparam logic [WW-1:0]    TMO_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0]    WAIT_ONE = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RACE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       idx_q, idx_d;
  logic [CW-1:0]          clr_q, clr_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic                   bit_q, bit_d;
  logic [RESP_BITS-1:0]   resp_q, resp_d;
  logic                   tie_q, tie_d;
  logic                   tmo_q, tmo_d;

  // State and datapath registers; reset returns everything to idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      clr_q   <= '0;
      wait_q  <= '0;
      bit_q   <= 1'b0;
      resp_q  <= '0;
      tie_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic and state-decoded control outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    clr_d       = clr_q;
    wait_d      = wait_q;
    bit_d       = bit_q;
    resp_d      = resp_q;
    tie_d       = tie_q;
    tmo_d       = tmo_q;
    counter_rst = 1'b1;
    ro_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          clr_d   = '0;
          resp_d  = '0;
          tie_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        busy   = 1'b1;
        wait_d = '0;
        if (clr_q == CLR_LAST) begin
          clr_d   = '0;
          state_d = S_RACE;
        end else begin
          clr_d = clr_q + CLR_ONE;
        end
      end
      S_RACE: begin
        busy        = 1'b1;
        counter_rst = 1'b0;
        ro_en       = 1'b1;
        wait_d      = wait_q + WAIT_ONE;
        // A finish pulse in the last permitted cycle still beats the timeout.
        if (fin_a && fin_b) begin
          bit_d   = 1'b0;
          tie_d   = 1'b1;
          state_d = S_CAPTURE;
        end else if (fin_a) begin
          bit_d   = 1'b1;
          state_d = S_CAPTURE;
        end else if (fin_b) begin
          bit_d   = 1'b0;
          state_d = S_CAPTURE;
        end else if (wait_q == TMO_LAST) begin
          bit_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        busy           = 1'b1;
        resp_d[idx_q]  = bit_q;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          clr_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pair_sel = idx_q;
  assign response = resp_q;
  assign tie_flag = tie_q;
  assign tmo_flag = tmo_q;

endmodule

// File: tb/tb_puf_race_ctrl.sv
// Self-checking bench for puf_race_ctrl: each run is described by the cycle
// (relative to ro_en rising) at which each counter finishes, and the expected
// response, flags and run length are derived from those delays directly.
module tb_puf_race_ctrl;

  localparam int NB  = 8;
  localparam int CLR = 4;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          fin_a = 1'b0;
  logic          fin_b = 1'b0;
  logic [2:0]    pair_sel;
  logic          counter_rst;
  logic          ro_en;
  logic          busy;
  logic          done;
  logic [NB-1:0] response;
  logic          tie_flag;
  logic          tmo_flag;

  int n_chk  = 0;
  int n_pass = 0;

  // finish delay per race; -1 = counter never finishes
  int plan_a[NB];
  int plan_b[NB];
  bit noise = 1'b0;

  puf_race_ctrl #(
    .RESP_BITS (NB),
    .SEL_W     (3),
    .CLR_CYCLES(CLR),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fin_a      (fin_a),
    .fin_b      (fin_b),
    .pair_sel   (pair_sel),
    .counter_rst(counter_rst),
    .ro_en      (ro_en),
    .busy       (busy),
    .done       (done),
    .response   (response),
    .tie_flag   (tie_flag),
    .tmo_flag   (tmo_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pair_sel"}, 32'(pair_sel), 0);
    chk({tag, "_counter_rst"}, 32'(counter_rst), 1);
    chk({tag, "_ro_en"}, 32'(ro_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_response"}, 32'(response), 0);
    chk({tag, "_tie"}, 32'(tie_flag), 0);
    chk({tag, "_tmo"}, 32'(tmo_flag), 0);
  endtask

  // Run one response; abort_r >= 0 asserts rst a few cycles into that race.
  task automatic run_resp(input int abort_r);
    int            exp_len[NB];
    logic [NB-1:0] exp_resp;
    bit            exp_tie;
    bit            exp_tmo;
    int            sum;
    int            r;
    int            k;
    int            clr;
    int            cyc;
    bit            in_race;
    bit            finished;

    exp_resp = '0;
    exp_tie  = 1'b0;
    exp_tmo  = 1'b0;
    sum      = 0;
    for (int i = 0; i < NB; i++) begin
      int ea;
      int eb;
      int m;
      ea = (plan_a[i] >= 0 && plan_a[i] < TMO) ? plan_a[i] : TMO;
      eb = (plan_b[i] >= 0 && plan_b[i] < TMO) ? plan_b[i] : TMO;
      m  = (ea < eb) ? ea : eb;
      if (m == TMO) begin
        exp_len[i] = TMO;
        exp_tmo    = 1'b1;
      end else begin
        exp_len[i] = m + 1;
        if (ea == eb) exp_tie = 1'b1;
        else if (ea < eb) exp_resp[i] = 1'b1;
      end
      sum += exp_len[i];
    end

    @(negedge clk);
    start = 1'b1;
    r = 0; k = 0; clr = 0; cyc = 0;
    in_race = 1'b0;
    finished = 1'b0;

    for (int n = 0; n < 1500 && !finished; n++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      fin_a = 1'b0;
      fin_b = 1'b0;
      if (cyc == 1) begin
        chk("accept_busy", 32'(busy), 1);
        chk("accept_resp_cleared", 32'(response), 0);
        chk("accept_tie_cleared", 32'(tie_flag), 0);
        chk("accept_tmo_cleared", 32'(tmo_flag), 0);
      end
      if (ro_en) begin
        if (!in_race) begin
          in_race = 1'b1;
          k = 0;
          chk("clear_len", 32'(clr), CLR);
          chk("pair_sel", 32'(pair_sel), 32'(r));
          chk("race_ctr_rst", 32'(counter_rst), 0);
        end else begin
          k++;
        end
        if (r == abort_r && k == 3) begin
          rst = 1'b1;
          #1;
          chk_reset_values("abort");
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        fin_a = (k == plan_a[r]);
        fin_b = (k == plan_b[r]);
      end else begin
        if (in_race) begin
          in_race = 1'b0;
          if (r < NB) chk("race_len", 32'(k + 1), 32'(exp_len[r]));
          r++;
          clr = 0;
        end
        if (busy && counter_rst && 32'(pair_sel) == r) clr++;
        if (noise && busy && counter_rst) begin
          fin_a = 1'($urandom_range(0, 1));
          fin_b = 1'($urandom_range(0, 1));
        end
        if (done) begin
          chk("busy_at_done", 32'(busy), 0);
          chk("run_len", 32'(cyc), 32'(NB * (CLR + 1) + sum + 1));
          chk("races_seen", 32'(r), NB);
          @(negedge clk);
          chk("done_one_cycle", 32'(done), 0);
          chk("response", 32'(response), 32'(exp_resp));
          chk("tie_flag", 32'(tie_flag), 32'(exp_tie));
          chk("tmo_flag", 32'(tmo_flag), 32'(exp_tmo));
          repeat (3) @(negedge clk);
          chk("response_hold", 32'(response), 32'(exp_resp));
          finished = 1'b1;
        end
      end
      if (noise && busy) start = 1'($urandom_range(0, 1));
    end
    if (!finished) chk("run_completed", 0, 1);
    start = 1'b0;
    fin_a = 1'b0;
    fin_b = 1'b0;
  endtask

  task automatic set_all(input int a, input int b);
    for (int i = 0; i < NB; i++) begin
      plan_a[i] = a;
      plan_b[i] = b;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_values("por");
    rst = 1'b0;

    // A always wins
    set_all(10, 12);
    run_resp(-1);

    // alternating winners, bit0 from A
    for (int i = 0; i < NB; i++) begin
      plan_a[i] = (i % 2 == 0) ? 10 : 12;
      plan_b[i] = (i % 2 == 0) ? 12 : 10;
    end
    run_resp(-1);

    // tie on race 3
    set_all(10, 12);
    plan_a[3] = 7;
    plan_b[3] = 7;
    run_resp(-1);

    // race 0 never finishes
    set_all(10, 12);
    plan_a[0] = -1;
    plan_b[0] = -1;
    run_resp(-1);

    // finish on the last permitted cycle vs. one cycle too late
    set_all(3, 5);
    plan_a[1] = TMO - 1; plan_b[1] = -1;
    plan_a[2] = -1;      plan_b[2] = TMO - 1;
    plan_a[3] = TMO;     plan_b[3] = TMO + 2;
    plan_a[4] = 0;       plan_b[4] = 1;
    run_resp(-1);

    // stray start and fin pulses outside RACE
    noise = 1'b1;
    set_all(10, 12);
    run_resp(-1);

    // reset during race 5, then a clean run
    for (int i = 0; i < NB; i++) begin
      plan_a[i] = (i % 3 == 0) ? 6 : 9;
      plan_b[i] = 8;
    end
    run_resp(5);
    run_resp(-1);

    // randomized races
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NB; i++) begin
        plan_a[i] = int'($urandom_range(0, TMO + 4)) - 1;
        plan_b[i] = int'($urandom_range(0, TMO + 4)) - 1;
      end
      run_resp(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
